// File: rtl/async_arb_pkg.sv
// Shared definitions for the asynchronous arbiter tree client endpoint.
package async_arb_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned STATE_W         = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_DRAIN   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_GRANTED = 3'd3;
  localparam logic [2:0] ST_REL     = 3'd4;

  // States in which a handshake phase is outstanding on the leaf.
  function automatic logic state_busy(input state_t st);
    return (st == ST_DRAIN) || (st == ST_REQ) || (st == ST_REL);
  endfunction

  // States in which the leaf request is asserted.
  function automatic logic state_req(input state_t st);
    return (st == ST_REQ) || (st == ST_GRANTED);
  endfunction

endpackage

// File: rtl/async_arb_sync.sv
// Multi-flop 1-bit synchroniser for a signal asynchronous to clk; clears on reset.
module async_arb_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_arbiter_client.sv
// Per-core endpoint of the asynchronous arbiter tree: converts lock/unlock
// commands into a 4-phase req/ack handshake on one tree leaf.
// Optional wait statistics enabled by macro ASYNC_ARB_CLIENT_STATS_EN.
module async_arbiter_client
  import async_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
`ifdef ASYNC_ARB_CLIENT_STATS_EN
  ,
  parameter int unsigned CNT_W       = CNT_W_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic lock_i,
  input  logic unlock_i,
  output logic granted_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic req_o,
  input  logic ack_i
`ifdef ASYNC_ARB_CLIENT_STATS_EN
  ,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic [CNT_W-1:0] max_wait_o
`endif
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  state_t            state_q;
  state_t            state_d;
  logic              ack_s;
  logic              cmd_bad;
  logic              done_d;
  logic [FILL_W-1:0] fill_q;
  logic              settled;

  async_arb_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_i),
    .q     (ack_s)
  );

  // The synchroniser is cleared by reset, so ack_s only reflects the real
  // leaf ack once it has been refilled; DRAIN must not trust it before then.
  assign settled = (fill_q == FILL_W'(SYNC_STAGES));

  // Next-state logic, command legality and completion pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cmd_bad = (lock_i && unlock_i) ||
              (lock_i && (state_q != ST_IDLE)) ||
              (unlock_i && (state_q != ST_GRANTED));
    case (state_q)
      ST_DRAIN: begin
        if (settled && !ack_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Never raise req while the previous ack is still visible.
        if (lock_i && !cmd_bad && !ack_s) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d = ST_GRANTED;
          done_d  = 1'b1;
        end
      end
      ST_GRANTED: begin
        if (unlock_i && !cmd_bad) state_d = ST_REL;
      end
      ST_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
  end

  // State register with registered, glitch-free outputs derived from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DRAIN;
      fill_q    <= '0;
      req_o     <= 1'b0;
      granted_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (!settled) fill_q <= fill_q + FILL_W'(1);
      req_o     <= state_req(state_d);
      granted_o <= (state_d == ST_GRANTED);
      busy_o    <= state_busy(state_d);
      done_o    <= done_d;
      err_o     <= cmd_bad;
    end
  end

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] max_wait_q;

  // Count cycles spent waiting for the grant and keep the worst case seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      max_wait_q <= '0;
    end else begin
      if ((state_q != ST_REQ) && (state_d == ST_REQ)) begin
        wait_cnt_q <= '0;
      end else if ((state_q == ST_REQ) && (wait_cnt_q != '1)) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_REQ) && (state_d == ST_GRANTED) && (wait_cnt_q > max_wait_q)) begin
        max_wait_q <= wait_cnt_q;
      end
    end
  end

  assign wait_cnt_o = wait_cnt_q;
  assign max_wait_o = max_wait_q;
`endif

endmodule

// File: tb/tb_async_arbiter_client.sv
// Self-checking bench for async_arbiter_client: directed scenarios plus a
// randomized run against a transaction-level protocol model.
`timescale 1ns/1ps
module tb_async_arbiter_client;

  localparam int unsigned S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, lock_i, unlock_i, ack_i;
  logic req_o, granted_o, busy_o, done_o, err_o;
  logic lock_b, unlock_b, ack_b;
  logic req_b, granted_b, busy_b, done_b, err_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  logic [15:0] wait_cnt, max_wait, wait_cnt_b, max_wait_b;
  logic        lock4, unlock4, ack4;
  logic        req4, granted4, busy4, done4, err4;
  logic [3:0]  wait4, max4;
`endif

  async_arbiter_client #(
    .SYNC_STAGES (S)
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    , .CNT_W     (16)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lock_i    (lock_i),
    .unlock_i  (unlock_i),
    .granted_o (granted_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .req_o     (req_o),
    .ack_i     (ack_i)
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    , .wait_cnt_o (wait_cnt),
    .max_wait_o   (max_wait)
`endif
  );

  async_arbiter_client #(
    .SYNC_STAGES (S)
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    , .CNT_W     (16)
`endif
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .lock_i    (lock_b),
    .unlock_i  (unlock_b),
    .granted_o (granted_b),
    .busy_o    (busy_b),
    .done_o    (done_b),
    .err_o     (err_b),
    .req_o     (req_b),
    .ack_i     (ack_b)
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    , .wait_cnt_o (wait_cnt_b),
    .max_wait_o   (max_wait_b)
`endif
  );

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  async_arbiter_client #(
    .SYNC_STAGES (S),
    .CNT_W       (4)
  ) dut4 (
    .clk        (clk),
    .reset      (reset),
    .lock_i     (lock4),
    .unlock_i   (unlock4),
    .granted_o  (granted4),
    .busy_o     (busy4),
    .done_o     (done4),
    .err_o      (err4),
    .req_o      (req4),
    .ack_i      (ack4),
    .wait_cnt_o (wait4),
    .max_wait_o (max4)
  );
`endif

  // Protocol-level reference model: phases of the lock transaction.
  typedef enum int {M_SETTLE, M_FREE, M_ASK, M_OWN, M_RET} mode_t;
  mode_t      m_mode = M_SETTLE;
  int         m_since = 0;
  logic       hist[$];
  logic [4:0] exp_vec = '0;

  // Leaf responder: ack follows req after a configurable delay.
  bit resp_en = 1'b0;
  int rise_dly = 3, fall_dly = 4, resp_wait = 0;
  bit resp_rand = 1'b0;
  int ack_rise_cyc = -1, ack_fall_cyc = -1;

  task automatic step(input logic rst, input logic lk, input logic ul);
    logic acks, bad, e_done;
    reset = rst; lock_i = lk; unlock_i = ul;
    @(posedge clk);
    cyc++;
    acks = hist[S-1];
    if (rst) begin
      hist = {};
      for (int i = 0; i < int'(S); i++) hist.push_back(1'b0);
      m_mode = M_SETTLE; m_since = 0; exp_vec = '0;
    end else begin
      hist.push_front(ack_i); void'(hist.pop_back());
      m_since++;
      bad = (lk && ul) || (lk && m_mode != M_FREE) || (ul && m_mode != M_OWN);
      e_done = 1'b0;
      case (m_mode)
        M_SETTLE: if (m_since > int'(S) && !acks) m_mode = M_FREE;
        M_FREE:   if (lk && !bad && !acks) m_mode = M_ASK;
        M_ASK:    if (acks) begin m_mode = M_OWN; e_done = 1'b1; end
        M_OWN:    if (ul && !bad) m_mode = M_RET;
        M_RET:    if (!acks) begin m_mode = M_FREE; e_done = 1'b1; end
        default:  m_mode = M_SETTLE;
      endcase
      exp_vec = {(m_mode == M_ASK || m_mode == M_OWN), (m_mode == M_OWN),
                 (m_mode == M_SETTLE || m_mode == M_ASK || m_mode == M_RET), e_done, bad};
    end
    #1;
    lock_i = 1'b0; unlock_i = 1'b0;
    if (resp_en) begin
      if (req_o !== ack_i) begin
        resp_wait++;
        if (resp_wait > (req_o ? rise_dly : fall_dly)) begin
          ack_i = req_o; resp_wait = 0;
          if (ack_i) ack_rise_cyc = cyc; else ack_fall_cyc = cyc;
          if (resp_rand) begin
            rise_dly = $urandom_range(0, 6); fall_dly = $urandom_range(0, 6);
          end
        end
      end else resp_wait = 0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < int'(S) + 1; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    ack_i = 1'b0; resp_en = 1'b0;
    do_reset();
    vectors++;
    if ({req_o, granted_o, busy_o, done_o, err_o} !== 5'b0) begin
      miscompares++; $display("FAIL reset_outputs got=%b exp=00000", {req_o, granted_o, busy_o, done_o, err_o});
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_drain_busy got=%b exp=1", busy_o);
    end
    for (int i = 0; i < int'(S); i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_settle got=%b exp=%b", {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
    end
  endtask

  task automatic test_basic();
    resp_en = 1'b1; rise_dly = 3; fall_dly = 4;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (req_o !== 1'b0) begin miscompares++; $display("FAIL basic_req_before got=%b exp=0", req_o); end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (req_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++; $display("FAIL basic_req_after_lock got req=%b busy=%b exp 1 1", req_o, busy_o);
    end
    for (int i = 0; i < 40 && !granted_o; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec) begin
        miscompares++; $display("FAIL basic_vec cyc=%0d got=%b exp=%b", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
    end
    vectors++;
    if (granted_o !== 1'b1 || done_o !== 1'b1 || cyc != ack_rise_cyc + int'(S) + 1) begin
      miscompares++; $display("FAIL basic_grant_latency got gnt=%b done=%b cyc=%0d exp 1 1 cyc=%0d", granted_o, done_o, cyc, ack_rise_cyc + int'(S) + 1);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (done_o !== 1'b0 || granted_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL basic_hold got done=%b gnt=%b busy=%b exp 0 1 0", done_o, granted_o, busy_o);
    end
  endtask

  task automatic test_release();
    step(1'b0, 1'b0, 1'b1);
    vectors++;
    if ({req_o, granted_o, busy_o} !== 3'b001) begin
      miscompares++; $display("FAIL release_first got=%b exp=001", {req_o, granted_o, busy_o});
    end
    for (int i = 0; i < 40 && !done_o; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec) begin
        miscompares++; $display("FAIL release_vec cyc=%0d got=%b exp=%b", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
    end
    vectors++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || cyc != ack_fall_cyc + int'(S) + 1) begin
      miscompares++; $display("FAIL release_done got done=%b busy=%b cyc=%0d exp 1 0 cyc=%0d", done_o, busy_o, cyc, ack_fall_cyc + int'(S) + 1);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({req_o, granted_o, busy_o, done_o} !== 4'b0) begin
      miscompares++; $display("FAIL release_idle got=%b exp=0000", {req_o, granted_o, busy_o, done_o});
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if (err_o !== 1'b1 || req_o !== 1'b0) begin
      miscompares++; $display("FAIL illegal_both got err=%b req=%b exp 1 0", err_o, req_o);
    end
    step(1'b0, 1'b0, 1'b1);
    vectors++;
    if (err_o !== 1'b1 || granted_o !== 1'b0) begin
      miscompares++; $display("FAIL illegal_unlock_idle got err=%b gnt=%b exp 1 0", err_o, granted_o);
    end
    rise_dly = 15;
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (err_o !== 1'b0 || req_o !== 1'b1) begin
      miscompares++; $display("FAIL illegal_legal_lock got err=%b req=%b exp 0 1", err_o, req_o);
    end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (err_o !== 1'b1 || req_o !== 1'b1 || granted_o !== 1'b0) begin
      miscompares++; $display("FAIL illegal_lock_req got err=%b req=%b gnt=%b exp 1 1 0", err_o, req_o, granted_o);
    end
    for (int i = 0; i < 40 && !granted_o; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec) begin
        miscompares++; $display("FAIL illegal_vec cyc=%0d got=%b exp=%b", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
    end
    vectors++;
    if (granted_o !== 1'b1) begin miscompares++; $display("FAIL illegal_grant_timeout got=%b exp=1", granted_o); end
    rise_dly = 3;
  endtask

  task automatic test_reset_mid_grant();
    resp_en = 1'b0;
    ack_i = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    vectors++;
    if (req_o !== 1'b0 || granted_o !== 1'b0) begin
      miscompares++; $display("FAIL midreset_outputs got req=%b gnt=%b exp 0 0", req_o, granted_o);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i == 4), 1'b0);
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec || busy_o !== 1'b1) begin
        miscompares++; $display("FAIL midreset_drain cyc=%0d got=%b exp=%b busy=1", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
      if (i == 4) begin
        vectors++;
        if (err_o !== 1'b1 || req_o !== 1'b0) begin
          miscompares++; $display("FAIL midreset_lock_err got err=%b req=%b exp 1 0", err_o, req_o);
        end
      end
    end
    ack_i = 1'b0;
    ack_fall_cyc = cyc;
    resp_en = 1'b1;
    for (int i = 0; i < 20 && busy_o; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec) begin
        miscompares++; $display("FAIL midreset_vec cyc=%0d got=%b exp=%b", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
    end
    vectors++;
    if (busy_o !== 1'b0 || cyc != ack_fall_cyc + int'(S) + 1) begin
      miscompares++; $display("FAIL midreset_exit got busy=%b cyc=%0d exp 0 cyc=%0d", busy_o, cyc, ack_fall_cyc + int'(S) + 1);
    end
  endtask

  task automatic test_two_clients();
    int owner, a_grant, a_done, b_grant, b_done, both, a_hold;
    owner = 0; a_grant = -1; a_done = -1; b_grant = -1; b_done = -1; both = 0; a_hold = 0;
    resp_en = 1'b0; ack_i = 1'b0; ack_b = 1'b0;
    do_reset();
    for (int i = 0; i < int'(S) + 2; i++) step(1'b0, 1'b0, 1'b0);
    lock_i = 1'b1; lock_b = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      lock_i = 1'b0; lock_b = 1'b0; unlock_i = 1'b0; unlock_b = 1'b0;
      if (granted_o && granted_b) both++;
      if (granted_o && a_grant < 0) a_grant = i;
      if (done_o && !granted_o && a_grant >= 0 && a_done < 0) a_done = i;
      if (granted_b && b_grant < 0) b_grant = i;
      if (done_b && !granted_b && b_grant >= 0 && b_done < 0) b_done = i;
      if (granted_o) begin a_hold++; if (a_hold == 6) unlock_i = 1'b1; end
      if (granted_b && i == b_grant + 5) unlock_b = 1'b1;
      case (owner)
        0: if (req_o) begin owner = 1; ack_i = 1'b1; end
           else if (req_b) begin owner = 2; ack_b = 1'b1; end
        1: if (!req_o) begin ack_i = 1'b0; owner = 0; end
        default: if (!req_b) begin ack_b = 1'b0; owner = 0; end
      endcase
    end
    vectors++;
    if (both != 0) begin miscompares++; $display("FAIL two_mutex got both_granted_cycles=%0d exp=0", both); end
    vectors++;
    if (a_grant < 0 || a_done < 0 || b_grant <= a_done) begin
      miscompares++; $display("FAIL two_order got a_grant=%0d a_done=%0d b_grant=%0d exp b_grant>a_done>=0", a_grant, a_done, b_grant);
    end
    vectors++;
    if (b_done < 0 || err_o !== 1'b0 || err_b !== 1'b0) begin
      miscompares++; $display("FAIL two_b_release got b_done=%0d err=%b%b exp done>=0 err=00", b_done, err_o, err_b);
    end
  endtask

  task automatic test_random();
    int r, dones;
    logic lk, ul, rs;
    dones = 0;
    ack_i = 1'b0; ack_b = 1'b0;
    resp_en = 1'b1; resp_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rs = (r < 2); lk = (r >= 2 && r < 20) || (r >= 32 && r < 36);
      ul = (r >= 20 && r < 36);
      step(rs, lk, ul);
      if (done_o) dones++;
      vectors++;
      if ({req_o, granted_o, busy_o, done_o, err_o} !== exp_vec) begin
        miscompares++; $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc, {req_o, granted_o, busy_o, done_o, err_o}, exp_vec);
      end
    end
    vectors++;
    if (dones < 4) begin miscompares++; $display("FAIL random_activity got dones=%0d exp>=4", dones); end
    resp_rand = 1'b0;
  endtask

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  task automatic test_stats();
    resp_en = 1'b1; rise_dly = 20; fall_dly = 2;
    do_reset();
    vectors++;
    if (wait_cnt !== 16'd0 || max_wait !== 16'd0) begin
      miscompares++; $display("FAIL stats_reset got wait=%0d max=%0d exp 0 0", wait_cnt, max_wait);
    end
    for (int i = 0; i < int'(S) + 2; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && !granted_o; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (max_wait !== 16'(20 + S)) begin
      miscompares++; $display("FAIL stats_max20 got=%0d exp=%0d", max_wait, 20 + S);
    end
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30 && busy_o; i++) step(1'b0, 1'b0, 1'b0);
    rise_dly = 5;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && !granted_o; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (wait_cnt !== 16'(5 + S + 1) || max_wait !== 16'(20 + S)) begin
      miscompares++; $display("FAIL stats_second got wait=%0d max=%0d exp %0d %0d", wait_cnt, max_wait, 5 + S + 1, 20 + S);
    end
    lock4 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    lock4 = 1'b0;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0);
    ack4 = 1'b1;
    for (int i = 0; i < 20 && !granted4; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (granted4 !== 1'b1 || wait4 !== 4'd15 || max4 !== 4'd15) begin
      miscompares++; $display("FAIL stats_saturate got gnt=%b wait=%0d max=%0d exp 1 15 15", granted4, wait4, max4);
    end
    ack4 = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; lock_i = 1'b0; unlock_i = 1'b0; ack_i = 1'b0;
    lock_b = 1'b0; unlock_b = 1'b0; ack_b = 1'b0;
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    lock4 = 1'b0; unlock4 = 1'b0; ack4 = 1'b0;
`endif
    for (int i = 0; i < int'(S); i++) hist.push_back(1'b0);
    test_reset();
    test_basic();
    test_release();
    test_illegal();
    test_reset_mid_grant();
    test_two_clients();
    test_random();
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
